kernel_pingpong_cu: RTL

KERNEL_PINGPONG_CU -- requirements
Module: kernel_pingpong_cu

---
 rtl/kernel_pingpong_cu.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/kernel_pingpong_cu.sv
// ============================================================================
// kernel_pingpong_cu : ping-pong BRAM control unit, stream-to-bank writer
//                      with a consumer-driven read address walker.
// Rev 1.0
// ============================================================================
`default_nettype none

module kernel_pingpong_cu #(
  parameter int CH_W        = 9,
  parameter int CHECK_TLAST = 1
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic [CH_W-1:0] channel_size,
  input  logic            load_start,
  input  logic            s_axis_tvalid,
  input  logic            s_axis_tlast,
  output logic            s_axis_tready,
  output logic            wea,
  output logic [CH_W-1:0] addra,
  output logic            wr_bank,
  output logic            load_done,
  output logic            load_err,
  input  logic            rd_next,
  output logic            rd_valid,
  output logic            enb,
  output logic [CH_W-1:0] addrb,
  output logic            rd_bank,
  output logic            last_channel,
  output logic [1:0]      bank_full
);

  localparam logic [CH_W-1:0] c_one  = {{(CH_W-1){1'b0}}, 1'b1};
  localparam logic [CH_W-1:0] c_zero = '0;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_FREE = 2'd1,
    S_LOAD      = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_wr_bank;
  logic            r_rd_bank;
  logic [1:0]      r_bank_full;
  logic [1:0]      w_bank_full_nxt;
  logic [CH_W-1:0] r_size_q [2];
  logic [CH_W-1:0] r_load_size;
  logic [CH_W-1:0] r_cnt;
  logic [CH_W-1:0] r_addrb;
  logic            r_tlast_err;
  logic            r_zero_err;

  logic            w_wr_full;
  logic            w_start;
  logic            w_start_zero;
  logic            w_beat;
  logic            w_last_beat;
  logic            w_tlast_bad;
  logic            w_rd_valid;
  logic            w_last_ch;
  logic            w_rd_adv;
  logic            w_release;
  logic            w_size_wr;
  logic [CH_W-1:0] w_size_val;

  assign w_wr_full    = r_bank_full[r_wr_bank];
  assign w_start      = (r_state == S_IDLE) && load_start && (channel_size != c_zero);
  assign w_start_zero = (r_state == S_IDLE) && load_start && (channel_size == c_zero);
  assign w_beat       = (r_state == S_LOAD) && s_axis_tvalid;
  assign w_last_beat  = w_beat && (r_cnt == (r_load_size - c_one));
  assign w_tlast_bad  = (CHECK_TLAST != 0) && w_beat && (s_axis_tlast != w_last_beat);

  assign w_rd_valid   = r_bank_full[r_rd_bank];
  assign w_last_ch    = w_rd_valid && (r_addrb == (r_size_q[r_rd_bank] - c_one));
  assign w_rd_adv     = w_rd_valid && rd_next;
  assign w_release    = w_rd_adv && w_last_ch;

  // The size of a bank still being read must not be overwritten, so the new
  // size only lands in size_q once the target bank is known to be free.
  assign w_size_wr  = ((r_state == S_IDLE) && w_start && !w_wr_full) ||
                      ((r_state == S_WAIT_FREE) && !w_wr_full);
  assign w_size_val = (r_state == S_IDLE) ? channel_size : r_load_size;

  always_comb begin
    w_state_nxt   = r_state;
    s_axis_tready = 1'b0;
    wea           = 1'b0;
    load_done     = 1'b0;
    load_err      = r_zero_err;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = w_wr_full ? S_WAIT_FREE : S_LOAD;
        end
      end
      S_WAIT_FREE: begin
        if (!w_wr_full) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        s_axis_tready = 1'b1;
        wea           = s_axis_tvalid;
        if (w_last_beat) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        load_done   = 1'b1;
        load_err    = r_zero_err | r_tlast_err;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Set and clear in one cycle always hit different banks, so both apply.
  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (r_state == S_DONE) begin
      w_bank_full_nxt[r_wr_bank] = 1'b1;
    end
    if (w_release) begin
      w_bank_full_nxt[r_rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_bank_full <= 2'b00;
      r_size_q[0] <= c_zero;
      r_size_q[1] <= c_zero;
      r_load_size <= c_zero;
      r_cnt       <= c_zero;
      r_addrb     <= c_zero;
      r_tlast_err <= 1'b0;
      r_zero_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bank_full <= w_bank_full_nxt;
      r_zero_err  <= w_start_zero;

      if (w_start) begin
        r_load_size <= channel_size;
        r_cnt       <= c_zero;
        r_tlast_err <= 1'b0;
      end else begin
        if (w_beat) begin
          r_cnt <= r_cnt + c_one;
        end
        if (w_tlast_bad) begin
          r_tlast_err <= 1'b1;
        end
      end

      if (w_size_wr) begin
        r_size_q[r_wr_bank] <= w_size_val;
      end

      if (r_state == S_DONE) begin
        r_wr_bank <= ~r_wr_bank;
      end

      if (w_rd_adv) begin
        if (w_last_ch) begin
          r_addrb   <= c_zero;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_addrb <= r_addrb + c_one;
        end
      end
    end
  end

  assign addra        = r_cnt;
  assign wr_bank      = r_wr_bank;
  assign rd_valid     = w_rd_valid;
  assign enb          = w_rd_valid;
  assign addrb        = r_addrb;
  assign rd_bank      = r_rd_bank;
  assign last_channel = w_last_ch;
  assign bank_full    = r_bank_full;

endmodule

`default_nettype wire
